// File: rtl/mem_sched_rr.sv
// Two-source (icache/dcache) memory request scheduler with read-outstanding tracking.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise dcache has fixed priority.
module mem_sched_rr #(
    parameter int ADDR_BITS       = 28,
    parameter int TAG_BITS        = 5,
    parameter int DATA_BEATS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ic_mem_req_valid,
    output logic                                 ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]                 ic_mem_req_addr,
    output logic                                 ic_mem_resp_valid,
    input  logic                                 dc_mem_req_valid,
    output logic                                 dc_mem_req_ready,
    input  logic                                 dc_mem_req_rw,
    input  logic [ADDR_BITS-1:0]                 dc_mem_req_addr,
    input  logic                                 dc_mem_req_data_valid,
    output logic                                 dc_mem_req_data_ready,
    output logic                                 dc_mem_resp_valid,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_rw,
    output logic [ADDR_BITS-1:0]                 mem_req_addr,
    output logic [TAG_BITS-1:0]                  mem_req_tag,
    output logic                                 mem_req_data_valid,
    input  logic                                 mem_req_data_ready,
    input  logic                                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]                  mem_resp_tag,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int BEAT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SEQ_W  = TAG_BITS - 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

    typedef enum logic {IDLE, WDATA} state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] rbeat_q, rbeat_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              lock_q, lock_d;
    logic              lock_src_q, lock_src_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              prio_dc_q, prio_dc_d;
`endif

    logic rd_ok, ic_elig, dc_elig, gnt_src, gnt_any;
    logic in_idle, in_wdata, req_v, accept, data_hs, resp_done, rd_acc, dec;

    always_comb begin
        rd_ok   = out_q < OUT_W'(MAX_OUTSTANDING);
        ic_elig = ic_mem_req_valid & rd_ok;
        dc_elig = dc_mem_req_valid & (dc_mem_req_rw | rd_ok);
        gnt_any = ic_elig | dc_elig;
        // A stalled winner stays granted even if the other side becomes eligible meanwhile.
        if (lock_q && (lock_src_q ? dc_elig : ic_elig)) begin
            gnt_src = lock_src_q;
        end else if (ic_elig && dc_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_src = prio_dc_q;
`else
            gnt_src = 1'b1;
`endif
        end else begin
            gnt_src = dc_elig;
        end
    end

    assign in_idle  = reset & (state_q == IDLE);
    assign in_wdata = reset & (state_q == WDATA);
    assign req_v    = in_idle & gnt_any;
    assign accept   = req_v & mem_req_ready;
    assign data_hs  = in_wdata & dc_mem_req_data_valid & mem_req_data_ready;

    assign mem_req_valid         = req_v;
    assign mem_req_rw            = req_v & gnt_src & dc_mem_req_rw;
    assign mem_req_addr          = gnt_src ? dc_mem_req_addr : ic_mem_req_addr;
    assign mem_req_tag           = {seq_q, gnt_src};
    assign ic_mem_req_ready      = accept & ~gnt_src;
    assign dc_mem_req_ready      = accept & gnt_src;
    assign mem_req_data_valid    = in_wdata & dc_mem_req_data_valid;
    assign dc_mem_req_data_ready = in_wdata & mem_req_data_ready;
    assign ic_mem_resp_valid     = reset & mem_resp_valid & ~mem_resp_tag[0];
    assign dc_mem_resp_valid     = reset & mem_resp_valid & mem_resp_tag[0];
    assign outstanding           = out_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rbeat_d    = rbeat_q;
        out_d      = out_q;
        seq_d      = seq_q;
        lock_d     = req_v & ~mem_req_ready;
        lock_src_d = gnt_src;
        resp_done  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        prio_dc_d  = accept ? ~gnt_src : prio_dc_q;
`endif
        if (accept) seq_d = seq_q + SEQ_W'(1);

        case (state_q)
            IDLE: begin
                if (accept && mem_req_rw) begin
                    state_d = WDATA;
                    beat_d  = '0;
                end
            end
            WDATA: begin
                if (data_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (mem_resp_valid) begin
            if (rbeat_q == LAST_BEAT) begin
                rbeat_d   = '0;
                resp_done = 1'b1;
            end else begin
                rbeat_d = rbeat_q + BEAT_W'(1);
            end
        end

        // Responses arriving with nothing tracked (e.g. after reset) must not underflow.
        rd_acc = accept & ~mem_req_rw;
        dec    = resp_done & (out_q != '0);
        if (rd_acc && !dec)      out_d = out_q + OUT_W'(1);
        else if (dec && !rd_acc) out_d = out_q - OUT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            rbeat_q    <= '0;
            out_q      <= '0;
            seq_q      <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dc_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rbeat_q    <= rbeat_d;
            out_q      <= out_d;
            seq_q      <= seq_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dc_q  <= prio_dc_d;
`endif
        end
    end

endmodule
